// File: rtl/counter_pkg.sv
// Shared encodings for the up/down modulus counter family.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'd0,
        MODE_SAT      = 2'd1,
        MODE_PINGPONG = 2'd2
    } mode_e;

    // ST_UP is 1 so the state bit doubles as the direction flag
    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } pp_state_e;

endpackage

// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with wrap, saturate or ping-pong behaviour at the
// range limits, a synchronous clamped load, and a one-cycle boundary pulse.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 7,
    parameter int unsigned MODULUS = 2**WIDTH,
    parameter mode_e       MODE    = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             dir
);

    localparam logic [WIDTH-1:0] MAX    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_M1 = MAX - ONE;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_load_clamp;
    pp_state_e        r_st;
    pp_state_e        w_st_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             w_dir;

    assign w_load_clamp = (load_val > MAX) ? MAX : load_val;

    // Next-state for count, ping-pong FSM and boundary pulse
    always_comb begin
        w_q_nxt   = r_q;
        w_st_nxt  = r_st;
        w_ovf_nxt = 1'b0;
        if (load) begin
            w_q_nxt = w_load_clamp;
            if (MODE == MODE_PINGPONG) begin
                if (w_load_clamp == MAX) begin
                    w_st_nxt = ST_DOWN;
                end else if (w_load_clamp == '0) begin
                    w_st_nxt = ST_UP;
                end
            end
        end else if (en) begin
            case (MODE)
                MODE_WRAP: begin
                    if (up_dn) begin
                        w_q_nxt   = (r_q == MAX) ? '0 : r_q + ONE;
                        w_ovf_nxt = (r_q == MAX);
                    end else begin
                        w_q_nxt   = (r_q == '0) ? MAX : r_q - ONE;
                        w_ovf_nxt = (r_q == '0);
                    end
                end
                MODE_SAT: begin
                    if (up_dn) begin
                        w_q_nxt   = (r_q == MAX) ? MAX : r_q + ONE;
                        w_ovf_nxt = (r_q == MAX);
                    end else begin
                        w_q_nxt   = (r_q == '0) ? '0 : r_q - ONE;
                        w_ovf_nxt = (r_q == '0);
                    end
                end
                MODE_PINGPONG: begin
                    if (r_st == ST_UP) begin
                        if (r_q == MAX) begin
                            w_st_nxt  = ST_DOWN;
                            w_q_nxt   = MAX_M1;
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_q_nxt = r_q + ONE;
                        end
                    end else begin
                        if (r_q == '0) begin
                            w_st_nxt  = ST_UP;
                            w_q_nxt   = ONE;
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_q_nxt = r_q - ONE;
                        end
                    end
                end
                default: begin
                    w_q_nxt = r_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= '0;
            r_st  <= ST_UP;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_st  <= w_st_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign w_dir = (MODE == MODE_PINGPONG) ? (r_st == ST_UP) : up_dn;
    assign dir   = w_dir;
    assign q     = r_q;
    assign ovf   = r_ovf;
    assign tc    = (w_dir && (r_q == MAX)) || (!w_dir && (r_q == '0));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: five counter configurations share one stimulus stream;
// each step queues the expected outputs of the instance under test.
module tb_updown_mod_counter;
    import counter_pkg::*;

    typedef struct {
        int         sel;
        logic [7:0] q;
        logic       tc;
        logic       ovf;
        logic       dir;
        string      name;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic       chk_req;

    logic [6:0] q0;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [1:0] q3;
    logic [7:0] q4;
    logic [4:0] tc_v;
    logic [4:0] ovf_v;
    logic [4:0] dir_v;

    exp_t sb[$];
    int   n_pass;
    int   n_tot;

    updown_mod_counter #(.WIDTH(7)) u0 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[6:0]), .q(q0), .tc(tc_v[0]), .ovf(ovf_v[0]), .dir(dir_v[0]));

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .MODE(MODE_WRAP)) u1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[3:0]), .q(q1), .tc(tc_v[1]), .ovf(ovf_v[1]), .dir(dir_v[1]));

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .MODE(MODE_SAT)) u2 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[3:0]), .q(q2), .tc(tc_v[2]), .ovf(ovf_v[2]), .dir(dir_v[2]));

    updown_mod_counter #(.WIDTH(2), .MODULUS(4), .MODE(MODE_PINGPONG)) u3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[1:0]), .q(q3), .tc(tc_v[3]), .ovf(ovf_v[3]), .dir(dir_v[3]));

    updown_mod_counter #(.WIDTH(8), .MODULUS(100), .MODE(MODE_WRAP)) u4 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q4), .tc(tc_v[4]), .ovf(ovf_v[4]), .dir(dir_v[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pop and compare on the falling edge after each checked step
    always @(negedge clk) begin
        if (chk_req) begin
            exp_t       e;
            logic [7:0] aq;
            n_tot++;
            if (sb.size() == 0) begin
                $display("FAIL scoreboard_empty: got no expected entry, required one");
            end else begin
                e = sb.pop_front();
                case (e.sel)
                    0:       aq = 8'(q0);
                    1:       aq = 8'(q1);
                    2:       aq = 8'(q2);
                    3:       aq = 8'(q3);
                    default: aq = q4;
                endcase
                if (aq == e.q && tc_v[e.sel] == e.tc && ovf_v[e.sel] == e.ovf
                    && dir_v[e.sel] == e.dir) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got q=%0d tc=%0b ovf=%0b dir=%0b, required q=%0d tc=%0b ovf=%0b dir=%0b",
                             e.name, aq, tc_v[e.sel], ovf_v[e.sel], dir_v[e.sel],
                             e.q, e.tc, e.ovf, e.dir);
                end
            end
        end
    end

    task automatic step(input int sel, input int r, input int e, input int u, input int l,
                        input int v, input int chk, input int eq, input int et,
                        input int eo, input int ed, input string nm);
        exp_t x;
        reset    = r[0];
        en       = e[0];
        up_dn    = u[0];
        load     = l[0];
        load_val = 8'(v);
        @(posedge clk);
        if (chk != 0) begin
            x.sel  = sel;
            x.q    = 8'(eq);
            x.tc   = et[0];
            x.ovf  = eo[0];
            x.dir  = ed[0];
            x.name = nm;
            sb.push_back(x);
            chk_req = 1'b1;
        end
        @(negedge clk);
        #1;
        chk_req = 1'b0;
    endtask

    int sat_q   [5] = '{8, 9, 9, 9, 9};
    int sat_tc  [5] = '{0, 1, 1, 1, 1};
    int sat_ovf [5] = '{0, 0, 1, 1, 1};
    int pp_q    [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int pp_dir  [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    int pp_ovf  [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    int pp_tc   [8] = '{0, 0, 1, 0, 0, 1, 0, 0};

    initial begin
        n_pass   = 0;
        n_tot    = 0;
        chk_req  = 1'b0;
        reset    = 1'b1;
        en       = 1'b0;
        up_dn    = 1'b0;
        load     = 1'b0;
        load_val = 8'd0;

        // Default 7-bit wrap counter: 130 up edges, wrap 127 -> 0
        step(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, "d0_reset");
        for (int k = 1; k <= 130; k++) begin
            step(0, 0, 1, 1, 0, 0, 1, k % 128, int'((k % 128) == 127),
                 int'(k == 128), 1, "d0_up_wrap");
        end

        // Modulus 10 wrap counting down from 0
        step(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, "d1_reset");
        for (int k = 1; k <= 12; k++) begin
            step(1, 0, 1, 0, 0, 0, 1, (10 - (k % 10)) % 10, int'((k % 10) == 0),
                 int'(k == 1 || k == 11), 0, "d1_down_wrap");
        end

        // Saturating modulus 10
        step(2, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, "d2_reset");
        step(2, 0, 1, 1, 1, 7, 1, 7, 0, 0, 1, "d2_load_over_en");
        for (int k = 0; k < 5; k++) begin
            step(2, 0, 1, 1, 0, 0, 1, sat_q[k], sat_tc[k], sat_ovf[k], 1, "d2_sat_up");
        end
        step(2, 0, 0, 1, 0, 0, 1, 9, 1, 0, 1, "d2_idle_hold");
        step(2, 0, 1, 0, 0, 0, 1, 8, 0, 0, 0, "d2_down");
        step(2, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, "d2_load_zero");
        step(2, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0, "d2_sat_low");

        // Ping-pong modulus 4, up_dn held low to show it is ignored
        step(3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, "d3_reset");
        for (int k = 0; k < 8; k++) begin
            step(3, 0, 1, 0, 0, 0, 1, pp_q[k], pp_tc[k], pp_ovf[k], pp_dir[k], "d3_pingpong");
        end
        step(3, 0, 0, 0, 1, 3, 1, 3, 0, 0, 0, "d3_load_max");
        step(3, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0, "d3_down_after_load");
        step(3, 1, 1, 0, 1, 3, 1, 0, 0, 0, 1, "d3_reset_over_load");
        step(3, 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, "d3_resume");

        // Modulus 100 in 8 bits: clamped load, load priority, reset priority
        step(4, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, "d4_reset");
        step(4, 0, 0, 1, 1, 30, 1, 30, 0, 0, 1, "d4_load");
        step(4, 0, 1, 1, 1, 200, 1, 99, 1, 0, 1, "d4_load_clamp_over_en");
        step(4, 0, 1, 1, 0, 0, 1, 0, 0, 1, 1, "d4_wrap");
        step(4, 0, 0, 1, 1, 49, 1, 49, 0, 0, 1, "d4_load49");
        step(4, 0, 1, 1, 0, 0, 1, 50, 0, 0, 1, "d4_count50");
        step(4, 1, 1, 1, 1, 7, 1, 0, 0, 0, 1, "d4_reset_over_load_en");
        step(4, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, "d4_resume");

        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "drain");
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 7: counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH: count range 0..MODULUS-1, with 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have parameter MODE, default MODE_WRAP: one of MODE_WRAP, MODE_SAT or MODE_PINGPONG.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port up_dn, input, 1 bit: 1 = up, 0 = down; ignored in MODE_PINGPONG.
REQ-008 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH bits: value to load.
REQ-010 SHALL have port q, output, WIDTH bits: registered count.
REQ-011 SHALL have port tc, output, 1 bit: combinational terminal count.
REQ-012 SHALL have port ovf, output, 1 bit: registered one-cycle boundary event pulse.
REQ-013 SHALL have port dir, output, 1 bit: effective direction, 1 = up.

Function
REQ-014 SHALL apply per-edge priority: reset, then load, then en; with none active, q holds and ovf = 0.
REQ-015 SHALL, on load, set q = min(load_val, MODULUS-1); ovf = 0 that cycle.
REQ-016 SHALL, in MODE_WRAP with en: up gives MAX->0, else q+1; down gives 0->MAX, else q-1 (MAX = MODULUS-1); ovf = 1 in the cycle after a wrap edge.
REQ-017 SHALL, in MODE_SAT with en: hold at MAX (up) or 0 (down) when at the limit; ovf = 1 in the cycle after each enabled edge spent at the limit.
REQ-018 SHALL, in MODE_PINGPONG, use a 2-state FSM, UP and DOWN. UP: q+1; at MAX, go to DOWN and q = MAX-1. DOWN: q-1; at 0, go to UP and q = 1. ovf = 1 after each reversal edge.
REQ-019 SHALL, in MODE_PINGPONG, set the FSM on load: to DOWN if the clamped value = MAX, to UP if it = 0, else unchanged.
REQ-020 SHALL drive dir = up_dn in MODE_WRAP and MODE_SAT, and the FSM state in MODE_PINGPONG.
REQ-021 SHALL drive tc = (dir && q==MAX) || (!dir && q==0), independent of en.
REQ-022 SHALL perform all arithmetic at WIDTH bits with no unintended truncation when MODULUS = 2**WIDTH.

Reset
REQ-023 SHALL, while reset = 1 at a clock edge, set q = 0, ovf = 0 and FSM = UP, regardless of load and en.
REQ-024 SHALL resume counting from 0 on the first edge after reset deasserts, with no spurious ovf.
REQ-025 SHALL, on reset asserted mid-count or mid-reversal, discard all pending state.

Structure
REQ-026 SHALL take MODE_WRAP, MODE_SAT, MODE_PINGPONG and the FSM state encodings from shared package counter_pkg.
REQ-027 SHALL contain no sub-modules; the next-state logic is a single combinational block feeding the q, FSM and ovf registers.

Verification
REQ-028 SHALL cover: defaults, reset 1 cycle, en = 1, up_dn = 1 for 130 cycles -> q counts 0..127, wraps to 0; ovf pulses once after the wrap; tc high at q = 127.
REQ-029 SHALL cover: MODULUS = 10, MODE_WRAP, down from 0 -> q goes 9, 8, ...; ovf after the 0->9 edge; tc at q = 0.
REQ-030 SHALL cover: MODE_SAT, MODULUS = 10, load 7, up 5 edges -> q = 8, 9, 9, 9, 9; ovf high for the 3 cycles after the held edges.
REQ-031 SHALL cover: MODE_PINGPONG, MODULUS = 4 -> q = 0, 1, 2, 3, 2, 1, 0, 1; dir flips at 3 and 0; ovf after each reversal.
REQ-032 SHALL cover: load_val = 200 with MODULUS = 100 -> q = 99; load and en together -> load wins.
REQ-033 SHALL cover: reset together with load = 1 and en = 1 at q = 50 -> q = 0, ovf = 0, dir = UP next cycle.
